// File: rtl/console_line_sink_pkg.sv
// Shared constants and state type for the console line sink.
// Provides ASCII control codes and the FILL/HOLD state enum.
package console_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

endpackage

// File: rtl/console_line_sink_if.sv
// Producer/reader bus of the console line sink.
// master: byte producer + line reader; slave: the sink itself.
interface console_line_sink_if #(
    parameter int LINE_LEN = 32,
    parameter int CNT_W    = 16
);
    localparam int AW = $clog2(LINE_LEN);
    localparam int LW = $clog2(LINE_LEN + 1);

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             line_valid;
    logic [LW-1:0]    line_len;
    logic             line_trunc;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data;
    logic             line_ack;
    logic [CNT_W-1:0] trunc_cnt;

    modport master (
        output in_valid, in_data, rd_addr, line_ack,
        input  in_ready, line_valid, line_len, line_trunc,
        input  rd_data, trunc_cnt
    );

    modport slave (
        input  in_valid, in_data, rd_addr, line_ack,
        output in_ready, line_valid, line_len, line_trunc,
        output rd_data, trunc_cnt
    );

endinterface

// File: rtl/line_buf_ram.sv
// LINE_LEN x 8 line buffer: one synchronous write port, async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module line_buf_ram #(
    parameter int LINE_LEN = 32,
    parameter int AW       = $clog2(LINE_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [LINE_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/console_line_sink.sv
// Console line sink: assembles ASCII bytes into a line, holds it until ack.
// Ports: clk, reset (sync, active-high), bus (slave side of console_line_sink_if).
// Optional CONSOLE_DISPLAY_EN: simulation-only echo of each completed line.
module console_line_sink
    import console_pkg::*;
#(
    parameter int LINE_LEN = 32,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                reset,
    console_line_sink_if.slave bus
);

    localparam int AW = $clog2(LINE_LEN);
    localparam int LW = $clog2(LINE_LEN + 1);

    state_t           state;
    logic [AW-1:0]    wr_ptr;
    logic             in_ready_q;
    logic             line_valid_q;
    logic [LW-1:0]    len_q;
    logic             trunc_q;
    logic [CNT_W-1:0] cnt_q;

    logic       accept;
    logic       is_lf;
    logic       is_cr;
    logic       we;
    logic       last_slot;
    logic [7:0] ram_q;

    assign accept    = bus.in_valid & in_ready_q;
    assign is_lf     = bus.in_data == ASCII_LF;
    assign is_cr     = bus.in_data == ASCII_CR;
    assign we        = accept & ~is_lf & ~is_cr;
    assign last_slot = wr_ptr == AW'(LINE_LEN - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            wr_ptr       <= '0;
            in_ready_q   <= 1'b1;
            line_valid_q <= 1'b0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept && is_lf) begin
                        len_q        <= LW'(wr_ptr);
                        trunc_q      <= 1'b0;
                        state        <= HOLD;
                        in_ready_q   <= 1'b0;
                        line_valid_q <= 1'b1;
                    end else if (we) begin
                        if (last_slot) begin
                            // Buffer full without LF: close the line as truncated.
                            len_q        <= LW'(LINE_LEN);
                            trunc_q      <= 1'b1;
                            state        <= HOLD;
                            in_ready_q   <= 1'b0;
                            line_valid_q <= 1'b1;
                            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.line_ack) begin
                        state        <= FILL;
                        wr_ptr       <= '0;
                        in_ready_q   <= 1'b1;
                        line_valid_q <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    line_buf_ram #(
        .LINE_LEN (LINE_LEN),
        .AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (bus.rd_addr),
        .rdata (ram_q)
    );

    assign bus.in_ready   = in_ready_q;
    assign bus.line_valid = line_valid_q;
    assign bus.line_len   = len_q;
    assign bus.line_trunc = trunc_q;
    assign bus.trunc_cnt  = cnt_q;
    // Stale characters beyond the held line read back as zero.
    assign bus.rd_data    = (line_valid_q && (LW'(bus.rd_addr) < len_q))
                          ? ram_q : 8'h00;

`ifdef CONSOLE_DISPLAY_EN
    logic shown_q;

    always_ff @(posedge clk) begin
        shown_q <= line_valid_q;
        if (line_valid_q && !shown_q) begin
            if (trunc_q) $write("[TRUNC] ");
            for (int i = 0; i < LINE_LEN; i++) begin
                if (LW'(i) < len_q) $write("%c", u_ram.mem[i]);
            end
            $write("\n");
        end
    end
`endif

endmodule

// File: tb/tb_console_line_sink.sv
// Directed bench for console_line_sink with a line scoreboard.
// Expected lines are queued when sent and checked when line_valid rises.
module tb_console_line_sink;

    localparam int LINE_LEN = 32;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    int    exp_len[$];
    bit    exp_trunc[$];
    string exp_str[$];

    console_line_sink_if #(.LINE_LEN(LINE_LEN), .CNT_W(CNT_W)) bus ();

    console_line_sink #(
        .LINE_LEN (LINE_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input string s, input bit tr);
        exp_str.push_back(s);
        exp_len.push_back(s.len());
        exp_trunc.push_back(tr);
    endtask

    // Present a byte and complete the handshake at the next accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic verify_line(input string tag);
        int    n;
        int    len;
        bit    tr;
        string s;
        n = 0;
        while (bus.line_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.line_valid), 32'd1);
        if (exp_len.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        len = exp_len.pop_front();
        tr  = exp_trunc.pop_front();
        s   = exp_str.pop_front();
        chk({tag, "_len"}, 32'(bus.line_len), 32'(len));
        chk({tag, "_trunc"}, 32'(bus.line_trunc), 32'(tr));
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < len; i++) begin
            bus.rd_addr = 5'(i);
            #1;
            chk({tag, "_char"}, 32'(bus.rd_data), 32'(s[i]));
        end
        if (len < LINE_LEN) begin
            bus.rd_addr = 5'(len);
            #1;
            chk({tag, "_past_end"}, 32'(bus.rd_data), 32'd0);
        end
    endtask

    task automatic ack_line(input string tag);
        @(negedge clk);
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(bus.line_valid), 32'd0);
        chk({tag, "_ack_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.rd_addr  = '0;
        bus.line_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_valid", 32'(bus.line_valid), 32'd0);
        chk("rst_len", 32'(bus.line_len), 32'd0);
        chk("rst_trunc", 32'(bus.line_trunc), 32'd0);
        chk("rst_cnt", 32'(bus.trunc_cnt), 32'd0);
        chk("rst_rd", 32'(bus.rd_data), 32'd0);

        // "Hi\n" back-to-back; line_valid the cycle after the LF.
        push_line("Hi", 1'b0);
        send_str("Hi\n");
        idle();
        chk("hi_latency", 32'(bus.line_valid), 32'd1);
        verify_line("hi");
        ack_line("hi");

        // 32 'A' with no LF: truncated line.
        push_line({LINE_LEN{"A"}}, 1'b1);
        for (int i = 0; i < LINE_LEN; i++) send(8'h41);
        idle();
        chk("full_latency", 32'(bus.line_valid), 32'd1);
        chk("full_cnt", 32'(bus.trunc_cnt), 32'd1);
        verify_line("full");
        ack_line("full");

        // LF after a truncated line starts a new empty line.
        push_line("", 1'b0);
        send(8'h0A);
        idle();
        verify_line("post_trunc_lf");
        ack_line("post_trunc_lf");

        // Lone LF, then "A\r\n" with CR dropped.
        push_line("", 1'b0);
        send(8'h0A);
        idle();
        verify_line("lone_lf");
        ack_line("lone_lf");
        push_line("A", 1'b0);
        send_str("A\r\n");
        idle();
        verify_line("cr");
        ack_line("cr");

        // Producer stalls on 'X' while a line is held.
        push_line("Q", 1'b0);
        send_str("Q\n");
        idle();
        verify_line("stall_q");
        bus.in_valid = 1'b1;
        bus.in_data  = "X";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("stall_len", 32'(bus.line_len), 32'd1);
        push_line("X", 1'b0);
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
        chk("stall_ready_after_ack", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        send(8'h0A);
        idle();
        verify_line("stall_x");
        ack_line("stall_x");

        // Reset mid-line discards "Hel" and clears the truncation count.
        send_str("Hel");
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(bus.trunc_cnt), 32'd0);
        chk("mid_rst_valid", 32'(bus.line_valid), 32'd0);
        push_line("ok", 1'b0);
        send_str("ok\n");
        idle();
        verify_line("after_rst");
        ack_line("after_rst");

        // Line printed by the optional display block.
        push_line("Hello", 1'b0);
        send_str("Hello\n");
        idle();
        verify_line("hello");
        ack_line("hello");

        chk("sb_drained", 32'(exp_len.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
